// File: rtl/irq_watchdog_timer.sv
// irq_watchdog_timer
//   Periodic IRQ generator plus watchdog for the 6502 subsystem, running off
//   the 3 kHz timebase. One WDCLR_n strobe both acknowledges the pending IRQ
//   and restarts the watchdog.
//
// Ports
//   clk_3kHz    in   timebase clock, rising edge
//   RESET_n     in   power-on reset, async, active-low
//   WDCLR_n     in   async clear strobe from the decoder, active-low
//   WD_EN       in   watchdog count enable (0 freezes the count)
//   IRQ_n       out  level interrupt, active-low
//   IRQ_TICK    out  one-clock pulse on each IRQ counter reload
//   WD_RESET_n  out  watchdog reset request, WD_PULSE clocks low
//   WD_TRIPPED  out  sticky: watchdog has fired since power-on
//   WD_COUNT    out  current watchdog count (debug)
//
// Watchdog FSM
//   state    | meaning
//   ST_RUN   | counting toward timeout, clears accepted
//   ST_FIRE  | WD_RESET_n held low, count parked at 0, clears ignored

module irq_watchdog_timer #(
  parameter int unsigned IRQ_RELOAD = 4,
  parameter int unsigned WD_BITS    = 8,
  parameter int unsigned WD_PULSE   = 4
) (
  input  logic               clk_3kHz,
  input  logic               RESET_n,
  input  logic               WDCLR_n,
  input  logic               WD_EN,
  output logic               IRQ_n,
  output logic               IRQ_TICK,
  output logic               WD_RESET_n,
  output logic               WD_TRIPPED,
  output logic [WD_BITS-1:0] WD_COUNT
);

  localparam logic [3:0] RELOAD_V = 4'(IRQ_RELOAD);
  localparam logic [3:0] PULSE_V  = 4'(WD_PULSE - 1);

  typedef enum logic {ST_RUN, ST_FIRE} wd_state_e;

  logic               clr_tgl_q, clr_tgl_d;
  logic               sync1_q, sync1_d;
  logic               sync2_q, sync2_d;
  logic               clr_ack_q, clr_ack_d;
  logic               clr_evt;

  logic [3:0]         irq_cnt_q, irq_cnt_d;
  logic               irq_n_q, irq_n_d;
  logic               irq_tick_q, irq_tick_d;
  logic               irq_reload;

  wd_state_e          state_q, state_d;
  logic [WD_BITS-1:0] wd_cnt_q, wd_cnt_d;
  logic [WD_BITS-1:0] wd_inc;
  logic [3:0]         pulse_cnt_q, pulse_cnt_d;
  logic               wd_reset_n_q, wd_reset_n_d;
  logic               wd_tripped_q, wd_tripped_d;

  // Strobe capture: a toggle on the strobe's own edge so pulses far shorter
  // than a clock period are never missed; the toggle crosses into clk_3kHz.
  always_comb clr_tgl_d = ~clr_tgl_q;

  always_ff @(negedge WDCLR_n or negedge RESET_n) begin
    if (!RESET_n) clr_tgl_q <= 1'b0;
    else          clr_tgl_q <= clr_tgl_d;
  end

  always_comb begin
    sync1_d   = clr_tgl_q;
    sync2_d   = sync1_q;
    clr_ack_d = sync2_q;
    clr_evt   = (sync2_q != clr_ack_q);
  end

  // IRQ counter; a reload on the same clock as a clear keeps IRQ_n low so
  // the new interrupt is not swallowed by the acknowledge.
  always_comb begin
    irq_reload = (irq_cnt_q == 4'hF);
    irq_cnt_d  = irq_reload ? RELOAD_V : irq_cnt_q + 4'd1;
    irq_n_d    = irq_n_q;
    if (irq_reload)   irq_n_d = 1'b0;
    else if (clr_evt) irq_n_d = 1'b1;
    irq_tick_d = irq_reload;
  end

  always_comb begin
    state_d      = state_q;
    wd_cnt_d     = wd_cnt_q;
    pulse_cnt_d  = pulse_cnt_q;
    wd_reset_n_d = wd_reset_n_q;
    wd_tripped_d = wd_tripped_q;
    wd_inc       = wd_cnt_q + WD_BITS'(1);
    case (state_q)
      ST_RUN: begin
        if (clr_evt) begin
          wd_cnt_d = '0;
        end else if (WD_EN) begin
          // Timeout is the incremented value reaching the MSB, so the
          // counter never wraps.
          if (wd_inc[WD_BITS-1]) begin
            state_d      = ST_FIRE;
            wd_cnt_d     = '0;
            wd_reset_n_d = 1'b0;
            wd_tripped_d = 1'b1;
            pulse_cnt_d  = PULSE_V;
          end else begin
            wd_cnt_d = wd_inc;
          end
        end
      end
      ST_FIRE: begin
        wd_cnt_d = '0;
        if (pulse_cnt_q == 4'd0) begin
          wd_reset_n_d = 1'b1;
          state_d      = ST_RUN;
        end else begin
          pulse_cnt_d = pulse_cnt_q - 4'd1;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk_3kHz or negedge RESET_n) begin
    if (!RESET_n) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      clr_ack_q    <= 1'b0;
      irq_cnt_q    <= 4'd0;
      irq_n_q      <= 1'b1;
      irq_tick_q   <= 1'b0;
      state_q      <= ST_RUN;
      wd_cnt_q     <= '0;
      pulse_cnt_q  <= 4'd0;
      wd_reset_n_q <= 1'b1;
      wd_tripped_q <= 1'b0;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      clr_ack_q    <= clr_ack_d;
      irq_cnt_q    <= irq_cnt_d;
      irq_n_q      <= irq_n_d;
      irq_tick_q   <= irq_tick_d;
      state_q      <= state_d;
      wd_cnt_q     <= wd_cnt_d;
      pulse_cnt_q  <= pulse_cnt_d;
      wd_reset_n_q <= wd_reset_n_d;
      wd_tripped_q <= wd_tripped_d;
    end
  end

  assign IRQ_n      = irq_n_q;
  assign IRQ_TICK   = irq_tick_q;
  assign WD_RESET_n = wd_reset_n_q;
  assign WD_TRIPPED = wd_tripped_q;
  assign WD_COUNT   = wd_cnt_q;

endmodule

// File: tb/tb_irq_watchdog_timer.sv
`timescale 1ns/1ps
module tb_irq_watchdog_timer;

  logic       clk_3kHz = 1'b0;
  logic       RESET_n  = 1'b0;
  logic       WDCLR_n  = 1'b1;
  logic       WD_EN    = 1'b1;
  logic       IRQ_n, IRQ_TICK, WD_RESET_n, WD_TRIPPED;
  logic [7:0] WD_COUNT;

  irq_watchdog_timer #(
    .IRQ_RELOAD(4),
    .WD_BITS   (8),
    .WD_PULSE  (4)
  ) dut (
    .clk_3kHz  (clk_3kHz),
    .RESET_n   (RESET_n),
    .WDCLR_n   (WDCLR_n),
    .WD_EN     (WD_EN),
    .IRQ_n     (IRQ_n),
    .IRQ_TICK  (IRQ_TICK),
    .WD_RESET_n(WD_RESET_n),
    .WD_TRIPPED(WD_TRIPPED),
    .WD_COUNT  (WD_COUNT)
  );

  always #50 clk_3kHz = ~clk_3kHz;

  // Rising-edge number since RESET_n release.
  int cyc;
  always @(posedge clk_3kHz or negedge RESET_n) begin
    if (!RESET_n) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  typedef enum int {K_IRQ, K_TICK, K_WDR, K_TRIP, K_CNT} kind_e;
  typedef struct {
    int    cyc;
    kind_e kind;
    int    exp;
  } sb_item_t;

  sb_item_t sb_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int observe(input kind_e k);
    case (k)
      K_IRQ:   return int'(IRQ_n);
      K_TICK:  return int'(IRQ_TICK);
      K_WDR:   return int'(WD_RESET_n);
      K_TRIP:  return int'(WD_TRIPPED);
      default: return int'(WD_COUNT);
    endcase
  endfunction

  function automatic string kname(input kind_e k);
    case (k)
      K_IRQ:   return "irq_n";
      K_TICK:  return "irq_tick";
      K_WDR:   return "wd_reset_n";
      K_TRIP:  return "wd_tripped";
      default: return "wd_count";
    endcase
  endfunction

  task automatic expect_at(input int c, input kind_e k, input int v);
    sb_item_t it;
    it.cyc  = c;
    it.kind = k;
    it.exp  = v;
    sb_q.push_back(it);
  endtask

  // Outputs sampled on the falling edge following rising edge number cyc.
  always @(negedge clk_3kHz) begin
    if (RESET_n === 1'b1) begin
      for (int i = sb_q.size() - 1; i >= 0; i--) begin
        if (sb_q[i].cyc == cyc) begin
          check_val($sformatf("%s@%0d", kname(sb_q[i].kind), cyc),
                    observe(sb_q[i].kind), sb_q[i].exp);
          sb_q.delete(i);
        end
      end
    end
  end

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk_3kHz);
  endtask

  task automatic drain(input string name);
    #5;
    check_val({"sb_drain_", name}, sb_q.size(), 0);
    sb_q.delete();
  endtask

  task automatic clr_pulse();
    #5  WDCLR_n = 1'b0;
    #20 WDCLR_n = 1'b1;
  endtask

  // Asserts reset off the clock edge, checks the async reset values at once,
  // then releases just after a falling edge so edge 1 is the next rising one.
  task automatic do_reset(input string name);
    @(negedge clk_3kHz);
    #5 RESET_n = 1'b0;
    #1;
    check_val({"rst_irq_n_", name},      int'(IRQ_n),      1);
    check_val({"rst_irq_tick_", name},   int'(IRQ_TICK),   0);
    check_val({"rst_wd_reset_n_", name}, int'(WD_RESET_n), 1);
    check_val({"rst_wd_tripped_", name}, int'(WD_TRIPPED), 0);
    check_val({"rst_wd_count_", name},   int'(WD_COUNT),   0);
    @(negedge clk_3kHz);
    #1 RESET_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL sim_timeout: got time %0t expected finish earlier", $time);
    $fatal(1, "simulation time limit");
  end

  initial begin
    // A: free-running IRQ grid and an unattended watchdog timeout.
    WD_EN = 1'b1;
    do_reset("a");
    expect_at(15, K_IRQ, 1);   expect_at(15, K_TICK, 0);
    expect_at(16, K_IRQ, 0);   expect_at(16, K_TICK, 1);
    expect_at(17, K_TICK, 0);  expect_at(27, K_TICK, 0);
    expect_at(28, K_TICK, 1);  expect_at(29, K_TICK, 0);
    expect_at(40, K_TICK, 1);  expect_at(40, K_IRQ, 0);
    expect_at(100, K_IRQ, 0);
    expect_at(127, K_WDR, 1);  expect_at(127, K_CNT, 127);
    expect_at(127, K_TRIP, 0);
    expect_at(128, K_WDR, 0);  expect_at(128, K_TRIP, 1);
    expect_at(128, K_CNT, 0);
    expect_at(131, K_WDR, 0);  expect_at(131, K_CNT, 0);
    expect_at(132, K_WDR, 1);  expect_at(132, K_CNT, 0);
    expect_at(133, K_CNT, 1);  expect_at(140, K_CNT, 8);
    expect_at(140, K_TRIP, 1);
    wait_cyc(142);
    drain("a");

    // B/C: acknowledge a pending IRQ, then land a clear on a reload edge.
    do_reset("b");
    expect_at(16, K_IRQ, 0);
    expect_at(22, K_IRQ, 0);   expect_at(22, K_CNT, 22);
    expect_at(23, K_IRQ, 1);   expect_at(23, K_CNT, 0);
    expect_at(27, K_IRQ, 1);   expect_at(27, K_CNT, 4);
    expect_at(28, K_IRQ, 0);   expect_at(28, K_TICK, 1);
    expect_at(28, K_CNT, 0);
    expect_at(29, K_IRQ, 0);   expect_at(40, K_TICK, 1);
    expect_at(155, K_WDR, 1);  expect_at(156, K_WDR, 0);
    wait_cyc(20);
    clr_pulse();
    wait_cyc(25);
    clr_pulse();
    wait_cyc(158);
    drain("b");

    // D: watchdog frozen by WD_EN for 200 clocks, then resumes.
    do_reset("d");
    expect_at(50, K_CNT, 50);  expect_at(100, K_CNT, 50);
    expect_at(200, K_TRIP, 0); expect_at(250, K_CNT, 50);
    expect_at(250, K_WDR, 1);  expect_at(251, K_CNT, 51);
    expect_at(327, K_CNT, 127); expect_at(327, K_WDR, 1);
    expect_at(328, K_WDR, 0);  expect_at(328, K_TRIP, 1);
    wait_cyc(50);
    WD_EN = 1'b0;
    wait_cyc(250);
    WD_EN = 1'b1;
    wait_cyc(330);
    drain("d");

    // E: power-on reset in the middle of the watchdog pulse.
    do_reset("e0");
    expect_at(128, K_WDR, 0);  expect_at(129, K_WDR, 0);
    expect_at(130, K_WDR, 0);  expect_at(130, K_TRIP, 1);
    wait_cyc(130);
    drain("e_fire");
    do_reset("e");
    expect_at(15, K_IRQ, 1);   expect_at(15, K_TICK, 0);
    expect_at(16, K_IRQ, 0);   expect_at(16, K_TICK, 1);
    expect_at(16, K_TRIP, 0);  expect_at(16, K_WDR, 1);
    wait_cyc(18);
    drain("e");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
